fetch: RTL and testbench

Instruction fetch stage directly upstream of the main decoder. Holds the program counter, issues one outstanding 32-bit instruction read at a time to the instruction memory port, and parks the returned word together with its PC in a single-entry output slot that the decode stage drains with a valid/ready handshake. A redirect input from execute reloads the PC, flushes the slot and squashes any in-flight response.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch.sv | 116 +++++++++++
 tb/tb_fetch.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the front end: fixed-width word aliases, the fetch
// sequencer state encoding and the PC helpers used by the fetch stage.
package fetch_pkg;

    typedef logic [31:0] u32;
    typedef logic [63:0] u64;

    typedef enum logic [1:0] {
        REQ     = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    localparam u64 FETCH_RESET_PC = 64'h0000_0000_8000_0000;
    localparam u64 INSTR_BYTES    = 64'd4;

    // Instructions are word aligned; the low two address bits are dropped.
    function automatic u64 align_pc(input u64 pc);
        return pc & ~64'd3;
    endfunction

    function automatic u64 next_pc(input u64 pc);
        return pc + INSTR_BYTES;
    endfunction

endpackage

// File: rtl/fetch.sv
// Instruction fetch stage: one outstanding 32-bit read at a time, a single
// output slot drained by decode, and a redirect that reloads the PC.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   REQ     | request for pc is offered while the output slot is empty
//   WAIT    | request accepted, the next response fills the slot
//   DISCARD | request accepted before a redirect, its response is dropped
module fetch
    import fetch_pkg::*;
#(
    parameter u64 RESET_PC = FETCH_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,

    output logic        imem_req_valid,
    output logic [63:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,

    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,

    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    input  logic        decode_ready
);

    fetch_state_t state_q, state_d;
    u64           pc_q, pc_d;
    logic         slot_valid_q, slot_valid_d;
    u32           slot_instr_q, slot_instr_d;
    u64           slot_pc_q, slot_pc_d;

    logic         req_fire;
    logic         drain;

    // Request side is a pure function of registers, so it cannot glitch
    // with memory handshake inputs and holds steady until accepted.
    assign imem_req_valid = (state_q == REQ) && !slot_valid_q;
    assign imem_req_addr  = pc_q;

    assign instr_valid = slot_valid_q;
    assign instr       = slot_instr_q;
    assign instr_pc    = slot_pc_q;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign drain    = slot_valid_q && decode_ready;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        slot_valid_d = slot_valid_q;
        slot_instr_d = slot_instr_q;
        slot_pc_d    = slot_pc_q;

        if (redirect_valid) begin
            pc_d         = align_pc(redirect_pc);
            slot_valid_d = 1'b0;
            case (state_q)
                REQ:     state_d = req_fire ? DISCARD : REQ;
                WAIT:    state_d = imem_resp_valid ? REQ : DISCARD;
                DISCARD: state_d = imem_resp_valid ? REQ : DISCARD;
                default: state_d = REQ;
            endcase
        end else begin
            if (drain) begin
                slot_valid_d = 1'b0;
            end
            // A response only ever lands with the slot empty, so the fill
            // below never collides with a drain in the same cycle.
            case (state_q)
                REQ: begin
                    if (req_fire) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        slot_valid_d = 1'b1;
                        slot_instr_d = imem_resp_data;
                        slot_pc_d    = pc_q;
                        pc_d         = next_pc(pc_q);
                        state_d      = REQ;
                    end
                end
                DISCARD: begin
                    if (imem_resp_valid) begin
                        state_d = REQ;
                    end
                end
                default: state_d = REQ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= REQ;
            pc_q         <= RESET_PC;
            slot_valid_q <= 1'b0;
            slot_instr_q <= '0;
            slot_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            slot_valid_q <= slot_valid_d;
            slot_instr_q <= slot_instr_d;
            slot_pc_q    <= slot_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for the fetch stage: responder memory model plus
// directed scenarios and a randomized run against a PC-stream model.
module tb_fetch;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready  = 1'b1;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data  = 32'h0;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        decode_ready;

    int n_cmp;
    int n_err;
    int cyc;

    int          mem_lat;
    bit          mem_rand;
    bit          rdy_rand;
    bit          pend;
    logic [63:0] paddr;
    int          cnt;
    bit          stalled;
    logic [63:0] acc_q[$];

    typedef struct {
        logic [63:0] pc;
        logic [31:0] w;
        int          c;
    } slot_t;
    slot_t got_q[$];

    fetch dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .decode_ready   (decode_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents are a fixed scramble of the address.
    function automatic logic [31:0] word(input logic [63:0] a);
        return (a[33:2] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    // Memory: accepts on ready, answers once after 1..4 cycles.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pend    <= 1'b0;
            cnt     <= 0;
            stalled <= 1'b0;
        end else begin
            stalled <= imem_req_valid && !imem_req_ready;
            if (pend) begin
                if (cnt == 0) pend <= 1'b0;
                else          cnt  <= cnt - 1;
            end
            if (imem_req_valid && imem_req_ready) begin
                pend  <= 1'b1;
                paddr <= imem_req_addr;
                cnt   <= mem_rand ? int'($urandom_range(0, 3)) : mem_lat - 1;
                acc_q.push_back(imem_req_addr);
            end
        end
    end

    always @(negedge clk) begin
        imem_resp_valid <= pend && (cnt == 0) && !reset;
        imem_resp_data  <= (pend && cnt == 0) ? word(paddr) : 32'h0;
        imem_req_ready  <= rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Advance one clock; record every instruction newly placed in the slot.
    task automatic cycle();
        bit    keep;
        slot_t s;
        keep = instr_valid && !decode_ready && !redirect_valid;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (instr_valid && !keep) begin
            s.pc = instr_pc;
            s.w  = instr;
            s.c  = cyc;
            got_q.push_back(s);
        end
    endtask

    task automatic wait_accept(input string tag);
        int k;
        k = 0;
        acc_q.delete();
        while (acc_q.size() == 0 && k < 30) begin
            cycle();
            k++;
        end
        n_cmp++;
        if (acc_q.size() == 0) begin
            n_err++;
            $display("FAIL %s_accept_timeout: no request accepted within 30 cycles", tag);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (imem_req_valid !== 1'b1) begin n_err++; $display("FAIL reset_req_valid: got %b want 1", imem_req_valid); end
        n_cmp++; if (imem_req_addr !== RST_PC) begin n_err++; $display("FAIL reset_req_addr: got %h want %h", imem_req_addr, RST_PC); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
        n_cmp++; if (instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want 0", instr); end
        n_cmp++; if (instr_pc !== 64'h0) begin n_err++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
        reset = 1'b0;
        #1;
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
            n_err++; $display("FAIL reset_release_req: got valid %b addr %h want 1 %h", imem_req_valid, imem_req_addr, RST_PC);
        end
    endtask

    task automatic test_stream();
        logic [63:0] p;
        got_q.delete();
        acc_q.delete();
        repeat (9) cycle();
        n_cmp++;
        if (got_q.size() < 3 || acc_q.size() < 3) begin
            n_err++;
            $display("FAIL stream_count: got %0d slots %0d requests, want >= 3 each", got_q.size(), acc_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                p = RST_PC + 64'(4 * i);
                n_cmp++; if (got_q[i].pc !== p) begin n_err++; $display("FAIL stream_pc%0d: got %h want %h", i, got_q[i].pc, p); end
                n_cmp++; if (got_q[i].w !== word(p)) begin n_err++; $display("FAIL stream_instr%0d: got %h want %h", i, got_q[i].w, word(p)); end
                n_cmp++; if (acc_q[i] !== p) begin n_err++; $display("FAIL stream_addr%0d: got %h want %h", i, acc_q[i], p); end
            end
            for (int i = 1; i < 3; i++) begin
                n_cmp++;
                if (got_q[i].c - got_q[i-1].c != 3) begin
                    n_err++; $display("FAIL stream_spacing%0d: got %0d cycles want 3", i, got_q[i].c - got_q[i-1].c);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int          k;
        logic [63:0] hp;
        hp = RST_PC + 64'd12;
        decode_ready = 1'b0;
        k = 0;
        while (!instr_valid && k < 20) begin
            cycle();
            k++;
        end
        n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL bp_fill_timeout: instr_valid %b want 1", instr_valid); end
        for (int i = 0; i < 10; i++) begin
            cycle();
            n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL bp_req_valid c%0d: got %b want 0", i, imem_req_valid); end
            n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL bp_instr_valid c%0d: got %b want 1", i, instr_valid); end
            n_cmp++; if (instr_pc !== hp) begin n_err++; $display("FAIL bp_instr_pc c%0d: got %h want %h", i, instr_pc, hp); end
            n_cmp++; if (instr !== word(hp)) begin n_err++; $display("FAIL bp_instr c%0d: got %h want %h", i, instr, word(hp)); end
        end
        decode_ready = 1'b1;
        cycle();
        n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== hp + 64'd4) begin
            n_err++; $display("FAIL bp_next_req: got valid %b addr %h want 1 %h", imem_req_valid, imem_req_addr, hp + 64'd4);
        end
    endtask

    task automatic test_redirect_wait();
        logic [31:0] stale;
        mem_lat = 3;
        wait_accept("rw");
        stale = (acc_q.size() > 0) ? word(acc_q[0]) : 32'h0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_8000_0100;
        cycle();
        redirect_valid = 1'b0;
        mem_lat = 1;
        acc_q.delete();
        got_q.delete();
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rw_discard_req: got %b want 0", imem_req_valid); end
        repeat (12) cycle();
        n_cmp++;
        if (got_q.size() == 0 || acc_q.size() == 0) begin
            n_err++; $display("FAIL rw_no_delivery: got %0d slots %0d requests", got_q.size(), acc_q.size());
        end else begin
            n_cmp++; if (acc_q[0] !== 64'h8000_0100) begin n_err++; $display("FAIL rw_req_addr: got %h want %h", acc_q[0], 64'h8000_0100); end
            n_cmp++; if (got_q[0].pc !== 64'h8000_0100) begin n_err++; $display("FAIL rw_instr_pc: got %h want %h", got_q[0].pc, 64'h8000_0100); end
            n_cmp++; if (got_q[0].w !== word(64'h8000_0100)) begin n_err++; $display("FAIL rw_instr: got %h want %h", got_q[0].w, word(64'h8000_0100)); end
            foreach (got_q[i]) begin
                n_cmp++; if (got_q[i].w === stale) begin n_err++; $display("FAIL rw_stale_word: slot %0d got stale %h", i, stale); end
            end
        end
    endtask

    task automatic test_redirect_resp();
        mem_lat = 2;
        wait_accept("rr");
        cycle();
        got_q.delete();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_8000_0103;
        cycle();
        redirect_valid = 1'b0;
        mem_lat = 1;
        n_cmp++; if (got_q.size() != 0 || instr_valid !== 1'b0) begin n_err++; $display("FAIL rr_resp_dropped: got %0d slots valid %b want 0", got_q.size(), instr_valid); end
        n_cmp++; if (imem_req_valid !== 1'b1) begin n_err++; $display("FAIL rr_req_valid: got %b want 1", imem_req_valid); end
        n_cmp++; if (imem_req_addr !== 64'h8000_0100) begin n_err++; $display("FAIL rr_req_addr: got %h want %h", imem_req_addr, 64'h8000_0100); end
    endtask

    task automatic test_wrap();
        int k;
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        cycle();
        redirect_valid = 1'b0;
        acc_q.delete();
        got_q.delete();
        k = 0;
        while (acc_q.size() < 2 && k < 30) begin
            cycle();
            k++;
        end
        n_cmp++;
        if (acc_q.size() < 2 || got_q.size() < 1) begin
            n_err++; $display("FAIL wrap_timeout: got %0d requests %0d slots", acc_q.size(), got_q.size());
        end else begin
            n_cmp++; if (got_q[0].pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_err++; $display("FAIL wrap_instr_pc: got %h want FFFFFFFFFFFFFFFC", got_q[0].pc); end
            n_cmp++; if (got_q[0].w !== word(64'hFFFF_FFFF_FFFF_FFFC)) begin n_err++; $display("FAIL wrap_instr: got %h", got_q[0].w); end
            n_cmp++; if (acc_q[1] !== 64'h0) begin n_err++; $display("FAIL wrap_next_addr: got %h want 0", acc_q[1]); end
        end
    endtask

    task automatic test_reset_mid();
        int k;
        mem_lat = 3;
        wait_accept("rm");
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (imem_req_valid !== 1'b1) begin n_err++; $display("FAIL rm_req_valid: got %b want 1", imem_req_valid); end
        n_cmp++; if (imem_req_addr !== RST_PC) begin n_err++; $display("FAIL rm_req_addr: got %h want %h", imem_req_addr, RST_PC); end
        n_cmp++; if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 64'h0) begin
            n_err++; $display("FAIL rm_slot: got valid %b instr %h pc %h want 0 0 0", instr_valid, instr, instr_pc);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        mem_lat = 1;
        acc_q.delete();
        got_q.delete();
        k = 0;
        while (got_q.size() == 0 && k < 20) begin
            cycle();
            k++;
        end
        n_cmp++;
        if (got_q.size() == 0 || acc_q.size() == 0) begin
            n_err++; $display("FAIL rm_timeout: no delivery after reset");
        end else begin
            n_cmp++; if (acc_q[0] !== RST_PC) begin n_err++; $display("FAIL rm_first_addr: got %h want %h", acc_q[0], RST_PC); end
            n_cmp++; if (got_q[0].pc !== RST_PC || got_q[0].w !== word(RST_PC)) begin
                n_err++; $display("FAIL rm_first_instr: got pc %h instr %h want %h %h", got_q[0].pc, got_q[0].w, RST_PC, word(RST_PC));
            end
        end
    endtask

    // Model: the delivered PCs form a +4 stream restarted at each redirect
    // target, and any outstanding request always targets the next PC due.
    task automatic test_random();
        logic [63:0] exp_pc;
        logic [63:0] tgt;
        bit          redir;
        int          n_deliv;
        slot_t       s;
        mem_rand = 1'b1;
        rdy_rand = 1'b1;
        tgt = {$urandom, $urandom};
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        cycle();
        redirect_valid = 1'b0;
        exp_pc = {tgt[63:2], 2'b00};
        got_q.delete();
        n_deliv = 0;
        for (int i = 0; i < 3000; i++) begin
            decode_ready = ($urandom_range(0, 3) != 0);
            redir        = ($urandom_range(0, 39) == 0);
            tgt          = {$urandom, $urandom};
            if ($urandom_range(0, 9) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            redirect_valid = redir;
            redirect_pc    = tgt;
            cycle();
            redirect_valid = 1'b0;
            while (got_q.size() > 0) begin
                s = got_q.pop_front();
                n_cmp++; if (s.pc !== exp_pc) begin n_err++; $display("FAIL rnd_pc c%0d: got %h want %h", cyc, s.pc, exp_pc); end
                n_cmp++; if (s.w !== word(exp_pc)) begin n_err++; $display("FAIL rnd_instr c%0d: got %h want %h", cyc, s.w, word(exp_pc)); end
                exp_pc = exp_pc + 64'd4;
                n_deliv++;
            end
            if (redir) exp_pc = {tgt[63:2], 2'b00};
            if (instr_valid) begin
                n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rnd_req_while_full c%0d: got %b want 0", cyc, imem_req_valid); end
            end
            if (imem_req_valid) begin
                n_cmp++; if (imem_req_addr !== exp_pc) begin n_err++; $display("FAIL rnd_req_addr c%0d: got %h want %h", cyc, imem_req_addr, exp_pc); end
            end
            if (stalled && !redir) begin
                n_cmp++; if (imem_req_valid !== 1'b1) begin n_err++; $display("FAIL rnd_req_dropped c%0d: got %b want 1", cyc, imem_req_valid); end
            end
        end
        n_cmp++; if (n_deliv < 200) begin n_err++; $display("FAIL rnd_progress: got %0d deliveries want >= 200", n_deliv); end
        mem_rand = 1'b0;
        rdy_rand = 1'b0;
        decode_ready = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc = 0;
        mem_lat = 1;
        mem_rand = 1'b0;
        rdy_rand = 1'b0;
        reset = 1'b1;
        decode_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 64'h0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_resp();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, compared %0d mismatched %0d", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

endmodule
